// File: rtl/fib_seq_pkg.sv
// Shared types and state encoding for the fib core stream adapter.
package fib_seq_pkg;

  localparam int FIB_DATA_W = 32;

  typedef logic [1:0] fib_state_t;

  localparam fib_state_t ST_IDLE = 2'd0;
  localparam fib_state_t ST_REQ  = 2'd1;
  localparam fib_state_t ST_WAIT = 2'd2;

  typedef logic signed [FIB_DATA_W-1:0] fib_res_t;

endpackage

// File: rtl/fib_seq_fifo.sv
// Small synchronous-pointer result FIFO with asynchronous reset; the head is
// registered only, so a pushed entry becomes visible on the following cycle.
module fib_seq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> !full);

endmodule

// File: rtl/fib_seq_adapter.sv
// Stream adapter in front of the fib core: valid/ready requests in, single-cycle
// req out, result captured on fin into a FIFO. Define FIB_SEQ_BYPASS_EN to answer n <= 0 locally.
module fib_seq_adapter
  import fib_seq_pkg::*;
#(
  parameter int DATA_W    = FIB_DATA_W,
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic                     i_w_clk,
  input  logic                     i_w_res_p,
  input  logic                     i_w_ce_p,
  input  logic                     i_w_n_valid,
  output logic                     o_r_n_ready,
  input  logic signed [DATA_W-1:0] i_w_n,
  output logic                     o_r_req_p,
  output logic signed [DATA_W-1:0] o_r_n,
  input  logic                     i_w_fin_p,
  input  logic signed [DATA_W-1:0] i_w_o,
  output logic                     o_r_o_valid,
  input  logic                     i_w_o_ready,
  output logic signed [DATA_W-1:0] o_r_o,
  output logic                     o_r_busy,
  output logic [CNT_W-1:0]         o_r_done_cnt
);

  fib_state_t               state_q, state_d;
  logic signed [DATA_W-1:0] n_q, n_d;
  logic                     req_q, req_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     push;
  logic signed [DATA_W-1:0] push_data;
  logic                     fifo_empty, fifo_full;
  logic [DATA_W-1:0]        fifo_head;
  logic                     accept, bypass;

  assign o_r_n_ready = (state_q == ST_IDLE) && !fifo_full;
  assign accept      = i_w_n_valid && o_r_n_ready && i_w_ce_p;

`ifdef FIB_SEQ_BYPASS_EN
  assign bypass = (i_w_n <= 0);
`else
  assign bypass = 1'b0;
`endif

  // The core zeroes its output one ce cycle after fin, so capture happens on the fin edge itself.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    req_d     = req_q;
    push      = 1'b0;
    push_data = i_w_o;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bypass) begin
            push      = 1'b1;
            push_data = '0;
          end else begin
            n_d     = i_w_n;
            req_d   = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (i_w_ce_p) begin
          req_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_w_ce_p && i_w_fin_p) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    cnt_d = push ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge i_w_clk or posedge i_w_res_p) begin
    if (i_w_res_p) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      req_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  fib_seq_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (i_w_clk),
    .rst       (i_w_res_p),
    .push      (push),
    .push_data (push_data),
    .pop       (o_r_o_valid && i_w_o_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign o_r_req_p    = req_q;
  assign o_r_n        = n_q;
  assign o_r_o_valid  = !fifo_empty;
  assign o_r_o        = fifo_head;
  assign o_r_busy     = (state_q != ST_IDLE);
  assign o_r_done_cnt = cnt_q;

endmodule

// File: tb/tb_fib_seq_adapter.sv
// Directed bench for fib_seq_adapter with a behavioural fib core attached.
module tb_fib_seq_adapter;

  logic clk = 1'b0;
  logic rst, ce, n_valid, n_ready, req, fin, o_valid, o_ready, busy;
  logic signed [31:0] n_in, n_to_core, core_o, o_data;
  logic [1:0] done_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int core_reqs = 0;
  int req_hi = 0;
  int acc_cnt = 0;
  int ce_mode = 0;
  logic signed [31:0] res_q[$];
  logic signed [31:0] last_core_n = '0;

  logic c_busy;
  int c_lat;
  logic signed [31:0] c_res;

  always #5 clk = ~clk;

  fib_seq_adapter #(.DATA_W(32), .OUT_DEPTH(2), .CNT_W(2)) dut (
    .i_w_clk      (clk),
    .i_w_res_p    (rst),
    .i_w_ce_p     (ce),
    .i_w_n_valid  (n_valid),
    .o_r_n_ready  (n_ready),
    .i_w_n        (n_in),
    .o_r_req_p    (req),
    .o_r_n        (n_to_core),
    .i_w_fin_p    (fin),
    .i_w_o        (core_o),
    .o_r_o_valid  (o_valid),
    .i_w_o_ready  (o_ready),
    .o_r_o        (o_data),
    .o_r_busy     (busy),
    .o_r_done_cnt (done_cnt)
  );

  function automatic logic signed [31:0] fib(input logic signed [31:0] n);
    longint a = 0;
    longint b = 1;
    longint t;
    if (n <= 0) return '0;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a[31:0];
  endfunction

  // Behavioural core: synchronous reset, samples req while idle, fixed latency, one-ce fin.
  always @(posedge clk) begin
    if (rst) begin
      c_busy <= 1'b0;
      fin    <= 1'b0;
      core_o <= '0;
      c_lat  <= 0;
    end else if (ce) begin
      if (fin) begin
        fin    <= 1'b0;
        core_o <= '0;
      end
      if (c_busy) begin
        if (c_lat == 0) begin
          fin    <= 1'b1;
          core_o <= c_res;
          c_busy <= 1'b0;
        end else begin
          c_lat <= c_lat - 1;
        end
      end else if (req && !fin) begin
        c_busy      <= 1'b1;
        c_lat       <= 3;
        c_res       <= fib(n_to_core);
        core_reqs   <= core_reqs + 1;
        last_core_n <= n_to_core;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && o_valid && o_ready) res_q.push_back(o_data);
    if (req) req_hi <= req_hi + 1;
    if (!rst && n_valid && n_ready && ce) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    int cyc = 0;
    ce = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ce = (ce_mode != 0) ? (cyc % 3 == 0) : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic signed [31:0] v);
    int base;
    base = acc_cnt;
    n_in = v;
    n_valid = 1'b1;
    for (int k = 0; k < 400 && acc_cnt == base; k++) begin
      @(posedge clk);
      #1;
    end
    n_valid = 1'b0;
    if (acc_cnt == base) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_res(input int target);
    for (int k = 0; k < 600 && res_q.size() < target; k++) begin
      @(posedge clk);
      #1;
    end
    chk("result_count", res_q.size(), target);
  endtask

  initial begin
    int b, h, r;
    logic signed [31:0] exp2[4];
    int exp_cnt[5];
    logic signed [31:0] exp_fib[5];
    exp2    = '{32'sd1, 32'sd1, 32'sd2, 32'sd6765};
    exp_cnt = '{1, 2, 3, 0, 1};
    exp_fib = '{32'sd1, 32'sd1, 32'sd2, 32'sd3, 32'sd5};
    rst = 1'b1;
    n_valid = 1'b0;
    n_in = '0;
    o_ready = 1'b1;

    // Reset values and a single n = 10 transaction
    do_reset();
    chk("rst_req", req, 0);
    chk("rst_n", n_to_core, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_o", o_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", done_cnt, 0);
    chk("rst_ready", n_ready, 1);
    b = core_reqs; h = req_hi; r = res_q.size();
    send(10);
    wait_res(r + 1);
    chk("t1_result", res_q[r], 55);
    chk("t1_core_reqs", core_reqs - b, 1);
    chk("t1_req_cycles", req_hi - h, 1);
    chk("t1_core_n", last_core_n, 10);
    chk("t1_cnt", done_cnt, 1);
    chk("t1_valid_after_pop", o_valid, 0);

    // Backpressure: two results fill the FIFO, then drain and continue
    do_reset();
    o_ready = 1'b0;
    r = res_q.size();
    send(1);
    send(2);
    tick(30);
    chk("t2_ready_full", n_ready, 0);
    chk("t2_valid", o_valid, 1);
    chk("t2_head", o_data, 1);
    chk("t2_cnt2", done_cnt, 2);
    o_ready = 1'b1;
    send(3);
    send(20);
    wait_res(r + 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_res%0d", i), res_q[r + i], exp2[i]);
    chk("t2_cnt_wrap", done_cnt, 0);

    // Sparse clock enable holds req until a ce edge
    do_reset();
    ce_mode = 1;
    b = core_reqs; h = req_hi; r = res_q.size();
    send(7);
    wait_res(r + 1);
    ce_mode = 0;
    chk("t3_req_cycles", req_hi - h, 3);
    chk("t3_core_reqs", core_reqs - b, 1);
    chk("t3_result", res_q[r], 13);

    // Reset while waiting on the core
    do_reset();
    r = res_q.size();
    send(30);
    tick(2);
    chk("t4_busy_wait", busy, 1);
    rst = 1'b1;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_req", req, 0);
    chk("t4_n", n_to_core, 0);
    chk("t4_valid", o_valid, 0);
    chk("t4_o", o_data, 0);
    chk("t4_cnt", done_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick(20);
    chk("t4_no_stale", res_q.size(), r);
    send(5);
    wait_res(r + 1);
    chk("t4_result", res_q[r], 5);
    chk("t4_cnt1", done_cnt, 1);

    // Non-positive n
    do_reset();
    b = core_reqs; r = res_q.size();
    send(-4);
`ifdef FIB_SEQ_BYPASS_EN
    chk("t5_valid_next", o_valid, 1);
    chk("t5_head", o_data, 0);
    chk("t5_busy", busy, 0);
    chk("t5_cnt", done_cnt, 1);
    wait_res(r + 1);
    chk("t5_core_reqs", core_reqs - b, 0);
`else
    wait_res(r + 1);
    chk("t5_core_reqs", core_reqs - b, 1);
    chk("t5_core_n", last_core_n, -4);
    chk("t5_cnt", done_cnt, 1);
`endif
    chk("t5_result", res_q[r], 0);

    // Two-bit counter wraps over five transactions
    do_reset();
    r = res_q.size();
    for (int i = 0; i < 5; i++) begin
      send(i + 1);
      wait_res(r + i + 1);
      chk($sformatf("t6_cnt%0d", i), done_cnt, exp_cnt[i]);
      chk($sformatf("t6_res%0d", i), res_q[r + i], exp_fib[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
